// File: rtl/direction_scheduler_if.sv
// direction_scheduler_if: game/key inputs and direction/queue outputs of the scheduler
interface direction_scheduler_if;
    logic       Game_en;
    logic       Game_tick;
    logic       Key_up;
    logic       Key_right;
    logic       Key_down;
    logic       Key_left;
    logic [1:0] Dir;
    logic       Dir_changed;
    logic       Key_drop;
    logic [2:0] Queue_level;
    logic [7:0] Turn_count;
    modport master (
        output Game_en, Game_tick, Key_up, Key_right, Key_down, Key_left,
        input  Dir, Dir_changed, Key_drop, Queue_level, Turn_count
    );
    modport slave (
        input  Game_en, Game_tick, Key_up, Key_right, Key_down, Key_left,
        output Dir, Dir_changed, Key_drop, Queue_level, Turn_count
    );
endinterface

// File: rtl/direction_scheduler.sv
// direction_scheduler: queues snake turn requests and applies one per game tick
module direction_scheduler #(
    parameter int         QUEUE_DEPTH = 2,
    parameter logic [1:0] RESET_DIR   = 2'b01
) (
    input logic Clk_50mhz,
    input logic Rst,
    direction_scheduler_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam int QW = 2 * QUEUE_DEPTH;
    localparam int IW = (QW > 2) ? $clog2(QW) : 1;
    state_t state, state_next;
    logic [QW-1:0] q, q_next;
    logic [2:0] count, count_next, widx;
    logic [1:0] dir, win, ref_dir;
    logic [7:0] turns;
    logic [IW-1:0] tail_idx, push_idx;
    logic run, key_any, key_multi, full, pop, push, changed, drop;
    always_comb state_next = bus.Game_en ? RUN : IDLE;
    // queue head sits in q[1:0]; entries shift down on every pop
    always_comb begin
        run       = state == RUN;
        key_any   = bus.Key_up | bus.Key_right | bus.Key_down | bus.Key_left;
        key_multi = (bus.Key_up & (bus.Key_right | bus.Key_down | bus.Key_left)) |
                    (bus.Key_right & (bus.Key_down | bus.Key_left)) |
                    (bus.Key_down & bus.Key_left);
        win       = bus.Key_up ? 2'b00 : bus.Key_right ? 2'b01 : bus.Key_down ? 2'b10 : 2'b11;
        tail_idx  = IW'({count - 3'd1, 1'b0});
        ref_dir   = (count != 3'd0) ? q[tail_idx +: 2] : dir;
        full      = count == 3'(QUEUE_DEPTH);
        pop       = run && bus.Game_tick && count != 3'd0;
        push      = run && key_any && win != ref_dir && win != (ref_dir ^ 2'b10) && (!full || pop);
        widx      = count - {2'b0, pop};
        push_idx  = IW'({widx, 1'b0});
        q_next    = pop ? q >> 2 : q;
        if (push) q_next[push_idx +: 2] = win;
        count_next = run ? count + {2'b0, push} - {2'b0, pop} : 3'd0;
    end
    always_ff @(posedge Clk_50mhz) begin
        if (Rst) begin
            state   <= IDLE;
            q       <= '0;
            count   <= 3'd0;
            dir     <= RESET_DIR;
            changed <= 1'b0;
            drop    <= 1'b0;
            turns   <= 8'd0;
        end else begin
            state   <= state_next;
            q       <= run ? q_next : '0;
            count   <= count_next;
            if (pop) dir <= q[1:0];
            changed <= pop;
            drop    <= run && key_any && (key_multi || !push);
            turns   <= turns + {7'b0, pop};
        end
    end
    assign bus.Dir         = dir;
    assign bus.Dir_changed = changed;
    assign bus.Key_drop    = drop;
    assign bus.Queue_level = count;
    assign bus.Turn_count  = turns;
endmodule

// File: tb/tb_direction_scheduler.sv
// tb_direction_scheduler: directed scoreboard bench for the snake direction scheduler
module tb_direction_scheduler;
    typedef struct {
        logic [1:0] dir;
        logic       chg;
        logic       drop;
        logic [2:0] lvl;
        logic [7:0] tc;
        string      tag;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    direction_scheduler_if bus();
    direction_scheduler #(.QUEUE_DEPTH(2), .RESET_DIR(2'b01)) dut (
        .Clk_50mhz(clk),
        .Rst(rst),
        .bus(bus)
    );
    always #10 clk = ~clk;
    task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask
    // k = {up, right, down, left}; expected values describe outputs after this edge
    task automatic cyc(input logic r, input logic en, input logic tk, input logic [3:0] k,
                       input logic [1:0] d, input logic c, input logic dr,
                       input logic [2:0] l, input logic [7:0] t, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.Game_en = en;
        bus.Game_tick = tk;
        {bus.Key_up, bus.Key_right, bus.Key_down, bus.Key_left} = k;
        sb.push_back('{dir: d, chg: c, drop: dr, lvl: l, tc: t, tag: tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".dir"}, {6'b0, bus.Dir}, {6'b0, e.dir});
        chk({e.tag, ".chg"}, {7'b0, bus.Dir_changed}, {7'b0, e.chg});
        chk({e.tag, ".drop"}, {7'b0, bus.Key_drop}, {7'b0, e.drop});
        chk({e.tag, ".lvl"}, {5'b0, bus.Queue_level}, {5'b0, e.lvl});
        chk({e.tag, ".tc"}, bus.Turn_count, e.tc);
    endtask
    initial begin
        bus.Game_en = 1'b0;
        bus.Game_tick = 1'b0;
        {bus.Key_up, bus.Key_right, bus.Key_down, bus.Key_left} = 4'b0;
        cyc(1, 0, 0, 4'b0000, 2'b01, 0, 0, 3'd0, 8'd0, "reset");
        cyc(0, 1, 0, 4'b0000, 2'b01, 0, 0, 3'd0, 8'd0, "enable");
        cyc(0, 1, 0, 4'b1000, 2'b01, 0, 0, 3'd1, 8'd0, "up_push");
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 4'b0000, 2'b01, 0, 0, 3'd1, 8'd0, "up_wait");
        cyc(0, 1, 1, 4'b0000, 2'b00, 1, 0, 3'd0, 8'd1, "up_tick");
        cyc(0, 1, 0, 4'b0000, 2'b00, 0, 0, 3'd0, 8'd1, "chg_pulse");
        cyc(0, 1, 0, 4'b0100, 2'b00, 0, 0, 3'd1, 8'd1, "right_push");
        cyc(0, 1, 1, 4'b0000, 2'b01, 1, 0, 3'd0, 8'd2, "right_tick");
        cyc(0, 1, 0, 4'b0001, 2'b01, 0, 1, 3'd0, 8'd2, "left_reverse");
        cyc(0, 1, 0, 4'b0000, 2'b01, 0, 0, 3'd0, 8'd2, "drop_pulse");
        cyc(0, 1, 0, 4'b0100, 2'b01, 0, 1, 3'd0, 8'd2, "same_dir");
        cyc(0, 1, 0, 4'b1001, 2'b01, 0, 1, 3'd1, 8'd2, "up_left_same");
        cyc(0, 1, 0, 4'b0001, 2'b01, 0, 0, 3'd2, 8'd2, "left_vs_tail");
        cyc(0, 1, 0, 4'b0010, 2'b01, 0, 1, 3'd2, 8'd2, "full_drop");
        cyc(0, 1, 1, 4'b0010, 2'b00, 1, 0, 3'd2, 8'd3, "full_push_pop");
        cyc(0, 1, 1, 4'b0000, 2'b11, 1, 0, 3'd1, 8'd4, "pop_left");
        cyc(0, 1, 1, 4'b0000, 2'b10, 1, 0, 3'd0, 8'd5, "pop_down");
        cyc(0, 1, 1, 4'b0000, 2'b10, 0, 0, 3'd0, 8'd5, "empty_tick");
        cyc(0, 1, 0, 4'b0001, 2'b10, 0, 0, 3'd1, 8'd5, "fill_left");
        cyc(0, 1, 0, 4'b1000, 2'b10, 0, 0, 3'd2, 8'd5, "fill_up");
        cyc(0, 0, 0, 4'b0000, 2'b10, 0, 0, 3'd2, 8'd5, "disable_run");
        cyc(0, 0, 0, 4'b0000, 2'b10, 0, 0, 3'd0, 8'd5, "disable_flush");
        cyc(0, 0, 1, 4'b1000, 2'b10, 0, 0, 3'd0, 8'd5, "idle_ignore");
        cyc(0, 0, 0, 4'b0011, 2'b10, 0, 0, 3'd0, 8'd5, "idle_nodrop");
        cyc(0, 1, 0, 4'b0000, 2'b10, 0, 0, 3'd0, 8'd5, "reenable");
        cyc(0, 1, 0, 4'b0001, 2'b10, 0, 0, 3'd1, 8'd5, "pre_reset_push");
        cyc(1, 1, 1, 4'b1000, 2'b01, 0, 0, 3'd0, 8'd0, "mid_reset");
        cyc(0, 1, 0, 4'b0000, 2'b01, 0, 0, 3'd0, 8'd0, "post_reset");
        cyc(0, 1, 1, 4'b0000, 2'b01, 0, 0, 3'd0, 8'd0, "post_reset_tick");
        // alternate up/right turns until the turn counter wraps
        for (int i = 1; i <= 256; i++) begin
            logic [7:0] prev, cur;
            prev = 8'(i - 1);
            cur = 8'(i);
            if (i % 2 == 1) begin
                cyc(0, 1, 0, 4'b1000, 2'b01, 0, 0, 3'd1, prev, "wrap_push_up");
                cyc(0, 1, 1, 4'b0000, 2'b00, 1, 0, 3'd0, cur, "wrap_tick_up");
            end else begin
                cyc(0, 1, 0, 4'b0100, 2'b00, 0, 0, 3'd1, prev, "wrap_push_right");
                cyc(0, 1, 1, 4'b0000, 2'b01, 1, 0, 3'd0, cur, "wrap_tick_right");
            end
        end
        cyc(0, 1, 0, 4'b0000, 2'b01, 0, 0, 3'd0, 8'd0, "wrapped");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/direction_scheduler.md
DIRECTION_SCHEDULER -- requirements
Module: direction_scheduler

Interface
REQ-001 Parameter: QUEUE_DEPTH, 2, number of pending direction entries held (legal values 1..4).
REQ-002 Parameter: RESET_DIR, 2'b01, direction loaded at reset (right).
REQ-003 Port: Clk_50mhz  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-004 Port: Rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 Port: Game_en  input  1  high = game running; low = scheduler idle.
REQ-006 Port: Game_tick  input  1  one-cycle pulse, snake advances one cell.
REQ-007 Port: Key_up, Key_right, Key_down, Key_left  input  1 each  one-cycle debounced key-press pulses.
REQ-008 Port: Dir  output  2  applied direction; 00 up, 01 right, 10 down, 11 left.
REQ-009 Port: Dir_changed  output  1  one-cycle pulse, Dir took a new value.
REQ-010 Port: Key_drop  output  1  one-cycle pulse, a key pulse was rejected.
REQ-011 Port: Queue_level  output  3  pending entries, 0..QUEUE_DEPTH.
REQ-012 Port: Turn_count  output  8  accepted turns applied since reset, wraps 255->0.

Function
REQ-013 FSM states IDLE and RUN; IDLE->RUN on Game_en=1; RUN->IDLE on Game_en=0; state registered, transition effective next cycle.
REQ-014 IDLE: queue flushed to empty, key pulses and Game_tick ignored, Key_drop=0, Dir held.
REQ-015 RUN: key arbitration is fixed priority Up > Right > Down > Left; at most one key evaluated per cycle.
REQ-016 Lower-priority keys pulsing in the same cycle are discarded with Key_drop=1 that cycle+1 (one pulse, regardless of count).
REQ-017 Reference direction = queue tail if queue non-empty, else Dir, sampled from start-of-cycle state.
REQ-018 Winning key rejected (Key_drop) if equal to reference or reverse of reference (reverse = ref XOR 2'b10).
REQ-019 Winning key rejected (Key_drop) if queue full and no pop in the same cycle; accepted if full and Game_tick pops that cycle.
REQ-020 Accepted key pushed to queue tail; Queue_level increments next cycle.
REQ-021 Game_tick in RUN with queue non-empty: head popped, Dir <= head next edge, Dir_changed=1 for one cycle, Turn_count += 1.
REQ-022 Game_tick with queue empty: Dir unchanged, Dir_changed=0, no error.
REQ-023 Simultaneous push and pop: Queue_level unchanged; pushed entry checked against pre-pop tail per REQ-017.
REQ-024 Key_drop and Dir_changed registered; latency exactly one cycle from causing input.
REQ-025 Queue_level never exceeds QUEUE_DEPTH nor underflows below 0.

Reset
REQ-026 Rst=1 at an edge: state IDLE, Dir=RESET_DIR, queue empty, Queue_level=0, Dir_changed=0, Key_drop=0, Turn_count=0.
REQ-027 Rst has priority over Game_en, Game_tick and keys in the same cycle; mid-operation reset discards pending entries.

Verification
REQ-028 Reset, Game_en=1, Key_up pulse, Game_tick 5 cycles later -> Queue_level 1 then 0, Dir=00, Dir_changed one pulse, Turn_count=1.
REQ-029 Dir=01, Key_left pulse -> Key_drop pulse, Queue_level stays 0, Dir stays 01.
REQ-030 Dir=01, Key_up then Key_left (no tick), then Key_down -> queue {00,11}, Key_down dropped (full); two ticks -> Dir 00 then 11.
REQ-031 Key_up and Key_left same cycle, Dir=01 -> Up queued, one Key_drop pulse.
REQ-032 Queue full {00,11}, Key_down with Game_tick same cycle -> Dir=00, queue {11,10}, Queue_level=2, no Key_drop.
REQ-033 Queue_level=2, Game_en dropped to 0 -> Queue_level=0 within 2 cycles, Dir unchanged, subsequent key pulses give no Key_drop.
